// File: rtl/gpio_in_pkg.sv
// Shared constants for the DE2 board input peripheral:
// register addresses, ID word and default debounce window.
package gpio_in_pkg;

  localparam logic [1:0] GPIO_ADDR_SW    = 2'd0;
  localparam logic [1:0] GPIO_ADDR_KEY   = 2'd1;
  localparam logic [1:0] GPIO_ADDR_FLAGS = 2'd2;
  localparam logic [1:0] GPIO_ADDR_ID    = 2'd3;

  localparam logic [31:0] GPIO_IN_ID = 32'h4750_4931;

  // 10 ms at 50 MHz
  localparam int GPIO_DB_CYCLES = 500_000;

endpackage

// File: rtl/debounce_bit.sv
// One-bit 2-flop synchronizer followed by a stability-window
// debouncer; dout only follows din after DB_CYCLES steady cycles.
module debounce_bit #(
  parameter int DB_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic          stable;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  // any return to the stable value restarts the window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= 1'b0;
      cnt    <= '0;
    end else if (s2 == stable) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      stable <= s2;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign dout = stable;

endmodule

// File: rtl/gpio_in_de2.sv
// DE2 key/switch input peripheral: debounced levels, press pulses,
// sticky read-to-clear press flags, irq and a registered read port.
module gpio_in_de2
  import gpio_in_pkg::*;
#(
  parameter int DB_CYCLES = GPIO_DB_CYCLES,
  parameter int N_KEY     = 4,
  parameter int N_SW      = 18
) (
  input  logic              CLOCK_50,
  input  logic              rst_n,
  input  logic [N_KEY-1:0]  key_n,
  input  logic [N_SW-1:0]   sw,
  input  logic              rd_en,
  input  logic [1:0]        rd_addr,
  output logic [31:0]       rd_data,
  output logic [N_KEY-1:0]  key_level,
  output logic [N_KEY-1:0]  key_press,
  output logic [N_SW-1:0]   sw_level,
  output logic              irq
);

  localparam int NB = N_KEY + N_SW;

  logic [NB-1:0]    raw;
  logic [NB-1:0]    lvl;
  logic [N_KEY-1:0] key_level_d;
  logic [N_KEY-1:0] rise;
  logic [N_KEY-1:0] flags;
  logic [N_KEY-1:0] flags_nxt;
  logic             clr;
  logic [31:0]      rd_mux;

  // buttons are active-low on the board; pressed = 1 internally
  assign raw = {sw, ~key_n};

  for (genvar i = 0; i < NB; i++) begin : g_db
    debounce_bit #(
      .DB_CYCLES (DB_CYCLES)
    ) u_db (
      .clk   (CLOCK_50),
      .rst_n (rst_n),
      .din   (raw[i]),
      .dout  (lvl[i])
    );
  end

  assign key_level = lvl[N_KEY-1:0];
  assign sw_level  = lvl[NB-1:N_KEY];

  assign rise = key_level & ~key_level_d;
  assign clr  = rd_en && (rd_addr == GPIO_ADDR_FLAGS);

  // a set on the same edge as a clear wins
  always_comb begin
    flags_nxt = clr ? '0 : flags;
    flags_nxt = flags_nxt | rise;
  end

  always_comb begin
    rd_mux = '0;
    case (rd_addr)
      GPIO_ADDR_SW:    rd_mux[N_SW-1:0]  = sw_level;
      GPIO_ADDR_KEY:   rd_mux[N_KEY-1:0] = key_level;
      GPIO_ADDR_FLAGS: rd_mux[N_KEY-1:0] = flags;
      default:         rd_mux            = GPIO_IN_ID;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      key_level_d <= '0;
      key_press   <= '0;
      flags       <= '0;
      irq         <= 1'b0;
    end else begin
      key_level_d <= key_level;
      key_press   <= rise;
      flags       <= flags_nxt;
      irq         <= |flags;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= rd_mux;
    end
  end

endmodule
